// File: rtl/right_shift_arbiter_pkg.sv
// ============================================================================
// right_shift_arbiter_pkg : shift-op encoding and round-robin search helpers
// Rev 1.0
// ============================================================================
`default_nettype none

package right_shift_arbiter_pkg;

  typedef enum logic {
    SHIFT_LOGICAL = 1'b0,
    SHIFT_ARITH   = 1'b1
  } shift_op_e;

  // Helpers are written for the largest arbiter in the family; callers
  // zero-extend their request vector and pass their own last index.
  localparam int RR_MAX_REQS = 64;
  localparam int RR_MAX_IW   = 6;

  typedef logic [RR_MAX_IW-1:0] rr_idx_t;

  typedef struct packed {
    logic    found;
    rr_idx_t idx;
  } rr_pick_t;

  function automatic rr_idx_t rr_next(input rr_idx_t idx, input rr_idx_t last);
    return (idx == last) ? '0 : idx + rr_idx_t'(1);
  endfunction

  // First valid requester at or after ptr, wrapping after last.
  function automatic rr_pick_t rr_search(input logic [RR_MAX_REQS-1:0] valid,
                                         input rr_idx_t                ptr,
                                         input rr_idx_t                last);
    rr_pick_t pick;
    rr_idx_t  cand;
    pick = '0;
    cand = ptr;
    for (int k = 0; k < RR_MAX_REQS; k++) begin
      if ((k <= int'(last)) && !pick.found && valid[cand]) begin
        pick.found = 1'b1;
        pick.idx   = cand;
      end
      cand = rr_next(cand, last);
    end
    return pick;
  endfunction

endpackage

`default_nettype wire

// File: rtl/right_shift_arbiter_shifter.sv
// ============================================================================
// right_shift_arbiter_shifter : combinational logical/arithmetic right barrel shifter
// Rev 1.0
// ============================================================================
`default_nettype none

module right_shift_arbiter_shifter
  import right_shift_arbiter_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int SW   = $clog2(WIDTH)
) (
  input  logic             i_op,
  input  logic [SW-1:0]    i_w,
  input  logic [WIDTH-1:0] i_a,
  output logic [WIDTH-1:0] o_y
);

  logic             fill;
  logic [WIDTH-1:0] stage [SW+1];

  assign fill     = (i_op == SHIFT_ARITH) && i_a[WIDTH-1];
  assign stage[0] = i_a;

  // Stage s shifts by 2**s when amount bit s is set.
  for (genvar s = 0; s < SW; s++) begin : g_stage
    localparam int DIST = 1 << s;
    assign stage[s+1] = i_w[s] ? {{DIST{fill}}, stage[s][WIDTH-1:DIST]} : stage[s];
  end

  assign o_y = stage[SW];

endmodule

`default_nettype wire

// File: rtl/right_shift_arbiter.sv
// ============================================================================
// right_shift_arbiter : round-robin sharing of one right shifter, registered response
// Rev 1.0
// ============================================================================
`default_nettype none

module right_shift_arbiter
  import right_shift_arbiter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int REQS  = 4,
  localparam int SW   = $clog2(WIDTH),
  localparam int IW   = $clog2(REQS)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [REQS-1:0]       REQ_VALID,
  output logic [REQS-1:0]       REQ_READY,
  input  logic [REQS-1:0]       REQ_OP,
  input  logic [REQS*SW-1:0]    REQ_W,
  input  logic [REQS*WIDTH-1:0] REQ_A,
  output logic                  RSP_VALID,
  input  logic                  RSP_READY,
  output logic [IW-1:0]         RSP_ID,
  output logic [WIDTH-1:0]      RSP_Y
);

  localparam rr_idx_t c_last_idx = rr_idx_t'(REQS - 1);

  logic                   rsp_valid_q, rsp_valid_d;
  logic [IW-1:0]          rsp_id_q,    rsp_id_d;
  logic [WIDTH-1:0]       rsp_y_q,     rsp_y_d;
  logic [IW-1:0]          ptr_q,       ptr_d;

  logic [RR_MAX_REQS-1:0] valid_ext;
  rr_idx_t                ptr_ext;
  rr_pick_t               pick;
  rr_idx_t                next_idx;
  logic                   unused_idx_bits;
  logic [IW-1:0]          winner;
  logic                   slot_free;
  logic                   grant;
  logic                   sel_op;
  logic [SW-1:0]          sel_w;
  logic [WIDTH-1:0]       sel_a;
  logic [WIDTH-1:0]       shift_y;
  logic [REQS-1:0]        req_ready;

  always_comb begin
    valid_ext                = '0;
    valid_ext[REQS-1:0]      = REQ_VALID;
    ptr_ext                  = '0;
    ptr_ext[IW-1:0]          = ptr_q;
    pick                     = rr_search(valid_ext, ptr_ext, c_last_idx);
    next_idx                 = rr_next(pick.idx, c_last_idx);
  end

  assign unused_idx_bits = ^{pick.idx, next_idx};
  assign winner          = pick.idx[IW-1:0];

  // Drain and refill of the response register may happen on the same edge.
  assign slot_free = !rsp_valid_q || RSP_READY;
  assign grant     = !RST && slot_free && pick.found;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < REQS; i++) begin
      req_ready[i] = grant && (winner == IW'(i));
    end
  end

  always_comb begin
    sel_op = 1'b0;
    sel_w  = '0;
    sel_a  = '0;
    for (int i = 0; i < REQS; i++) begin
      if (winner == IW'(i)) begin
        sel_op = REQ_OP[i];
        sel_w  = REQ_W[i*SW +: SW];
        sel_a  = REQ_A[i*WIDTH +: WIDTH];
      end
    end
  end

  right_shift_arbiter_shifter #(
    .WIDTH (WIDTH)
  ) u_shifter (
    .i_op (sel_op),
    .i_w  (sel_w),
    .i_a  (sel_a),
    .o_y  (shift_y)
  );

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_y_d     = rsp_y_q;
    ptr_d       = ptr_q;
    if (grant) begin
      rsp_valid_d = 1'b1;
      rsp_id_d    = winner;
      rsp_y_d     = shift_y;
      ptr_d       = next_idx[IW-1:0];
    end else if (RSP_READY) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_y_q     <= '0;
      ptr_q       <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_y_q     <= rsp_y_d;
      ptr_q       <= ptr_d;
    end
  end

  assign REQ_READY = req_ready;
  assign RSP_VALID = rsp_valid_q;
  assign RSP_ID    = rsp_id_q;
  assign RSP_Y     = rsp_y_q;

  a_ready_onehot : assert property (@(posedge CLK) $onehot0(REQ_READY));
  a_ptr_range    : assert property (@(posedge CLK) disable iff (RST) int'(ptr_q) < REQS);
  a_no_grant_stall : assert property (@(posedge CLK)
                       (rsp_valid_q && !RSP_READY) |-> (REQ_READY == '0));

endmodule

`default_nettype wire
